// File: rtl/plic_src_conditioner_if.sv
// Sideband bundle between the interrupt sources and the conditioner:
// raw lines and configuration in, conditioned levels, edge pulses and the
// selected event count out.
interface plic_src_conditioner_if #(
    parameter int N_SOURCE = 30,
    parameter int FILT_W   = 4,
    parameter int SRCW     = $clog2(N_SOURCE + 1)
);
    logic [N_SOURCE-1:0] irq_raw;   // raw device lines, asynchronous
    logic [N_SOURCE-1:0] pol;       // 1 = source is active-low
    logic [N_SOURCE-1:0] filt_en;   // 1 = glitch filter enabled
    logic [FILT_W-1:0]   filt_len;  // global filter length, 0 behaves as 1
    logic [SRCW-1:0]     cnt_sel;   // event-counter select
    logic                cnt_clr;   // clear the selected event counter
    logic [N_SOURCE-1:0] irq_lvl;   // conditioned active-high level
    logic [N_SOURCE-1:0] rise;      // one-cycle pulse on 0->1 of irq_lvl
    logic [15:0]         cnt;       // registered event count

    modport master (
        output irq_raw, pol, filt_en, filt_len, cnt_sel, cnt_clr,
        input  irq_lvl, rise, cnt
    );

    modport slave (
        input  irq_raw, pol, filt_en, filt_len, cnt_sel, cnt_clr,
        output irq_lvl, rise, cnt
    );
endinterface

// File: rtl/plic_src_conditioner.sv
// Per-source interrupt conditioner feeding the PLIC source vector.
// Each raw line is synchronised, polarity corrected and glitch filtered;
// the block emits a clean level and a one-cycle rising-edge pulse.
// Optional feature macro: PLIC_SRC_EVENT_CNT_EN adds a 16-bit saturating
// rise counter per source with a selectable, registered read-out. Without
// it the count output is constant zero.
module plic_src_conditioner #(
    parameter int N_SOURCE    = 30,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int SRCW        = $clog2(N_SOURCE + 1)
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    plic_src_conditioner_if.slave bus
);

    logic [N_SOURCE-1:0] sync_r [SYNC_STAGES];
    logic [N_SOURCE-1:0] src_s;
    logic [N_SOURCE-1:0] q_r;
    logic [N_SOURCE-1:0] q_nxt_s;
    logic [N_SOURCE-1:0] rise_r;
    logic [FILT_W-1:0]   c_r     [N_SOURCE];
    logic [FILT_W-1:0]   c_nxt_s [N_SOURCE];
    logic                bypass_all_s;

    // Synchroniser chain: stage 0 samples the raw asynchronous lines.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {N_SOURCE{1'b0}};
            end
        end else begin
            sync_r[0] <= bus.irq_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Polarity is applied after synchronisation, so a pol change is seen at once.
    assign src_s        = sync_r[SYNC_STAGES-1] ^ bus.pol;
    assign bypass_all_s = (bus.filt_len <= FILT_W'(1));

    // Glitch filter: the level only follows src after it has differed for filt_len cycles.
    always_comb begin
        q_nxt_s = q_r;
        c_nxt_s = c_r;
        for (int k = 0; k < N_SOURCE; k++) begin
            if (!bus.filt_en[k] || bypass_all_s) begin
                q_nxt_s[k] = src_s[k];
                c_nxt_s[k] = {FILT_W{1'b0}};
            end else if (src_s[k] == q_r[k]) begin
                c_nxt_s[k] = {FILT_W{1'b0}};
            end else if (c_r[k] >= (bus.filt_len - FILT_W'(1))) begin
                // >= lets a lowered length commit at once instead of wrapping
                q_nxt_s[k] = src_s[k];
                c_nxt_s[k] = {FILT_W{1'b0}};
            end else begin
                c_nxt_s[k] = c_r[k] + FILT_W'(1);
            end
        end
    end

    // Filter state, level and edge pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_r    <= {N_SOURCE{1'b0}};
            rise_r <= {N_SOURCE{1'b0}};
            for (int k = 0; k < N_SOURCE; k++) begin
                c_r[k] <= {FILT_W{1'b0}};
            end
        end else begin
            q_r    <= q_nxt_s;
            rise_r <= q_nxt_s & ~q_r;
            c_r    <= c_nxt_s;
        end
    end

    assign bus.irq_lvl = q_r;
    assign bus.rise    = rise_r;

`ifdef PLIC_SRC_EVENT_CNT_EN
    logic [15:0] evt_r [N_SOURCE];
    logic [15:0] cnt_r;
    logic        sel_ok_s;

    assign sel_ok_s = (bus.cnt_sel < SRCW'(N_SOURCE));

    // Saturating rise counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_SOURCE; k++) begin
                evt_r[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < N_SOURCE; k++) begin
                if (bus.cnt_clr && sel_ok_s && (bus.cnt_sel == SRCW'(k))) begin
                    evt_r[k] <= 16'd0;
                end else if (rise_r[k] && (evt_r[k] != 16'hFFFF)) begin
                    evt_r[k] <= evt_r[k] + 16'd1;
                end else begin
                    evt_r[k] <= evt_r[k];
                end
            end
        end
    end

    // Registered read-out of the selected counter; out-of-range selects read zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= 16'd0;
        end else if (sel_ok_s) begin
            cnt_r <= evt_r[bus.cnt_sel];
        end else begin
            cnt_r <= 16'd0;
        end
    end

    assign bus.cnt = cnt_r;
`else
    logic unused_cnt_cfg_s;

    assign unused_cnt_cfg_s = ^{bus.cnt_sel, bus.cnt_clr};
    assign bus.cnt          = 16'd0;
`endif

endmodule

// File: tb/tb_plic_src_conditioner.sv
// Scoreboard bench for plic_src_conditioner: a cycle-level reference model
// predicts the outputs after every clock edge, a monitor compares them.
module tb_plic_src_conditioner;

    localparam int N    = 30;
    localparam int SYNC = 2;
    localparam int FW   = 4;
    localparam int SW   = $clog2(N + 1);

    typedef struct {
        logic [N-1:0] irq;
        logic [N-1:0] rise;
        logic [15:0]  cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    plic_src_conditioner_if #(.N_SOURCE(N), .FILT_W(FW), .SRCW(SW)) bus ();

    plic_src_conditioner #(
        .N_SOURCE(N), .SYNC_STAGES(SYNC), .FILT_W(FW), .SRCW(SW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // current stimulus
    logic [N-1:0]  cur_irq, cur_pol, cur_en;
    logic [FW-1:0] cur_len;
    logic [SW-1:0] cur_sel;
    logic          cur_clr;

    // reference model state
    logic [N-1:0] m_hist [SYNC];   // m_hist[0] = line value seen at the latest edge
    logic [N-1:0] m_q, m_rise;
    int           m_diff [N];      // consecutive cycles the input disagreed with the level
    int           m_evt  [N];
    logic [15:0]  m_cnt;

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
        m_q = '0; m_rise = '0; m_cnt = 16'd0;
        for (int k = 0; k < N; k++) begin m_diff[k] = 0; m_evt[k] = 0; end
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: apply stimulus, predict the post-edge outputs, queue them.
    task automatic step();
        logic [N-1:0] s, nq;
        int           len, sel;
        exp_t         e;
        bus.irq_raw  = cur_irq;
        bus.pol      = cur_pol;
        bus.filt_en  = cur_en;
        bus.filt_len = cur_len;
        bus.cnt_sel  = cur_sel;
        bus.cnt_clr  = cur_clr;
        s   = m_hist[SYNC-1] ^ cur_pol;
        len = int'(cur_len);
        sel = int'(cur_sel);
        nq  = m_q;
        for (int k = 0; k < N; k++) begin
            if (!cur_en[k] || len <= 1) begin
                nq[k] = s[k]; m_diff[k] = 0;
            end else if (s[k] == m_q[k]) begin
                m_diff[k] = 0;
            end else begin
                m_diff[k]++;
                if (m_diff[k] >= len) begin nq[k] = s[k]; m_diff[k] = 0; end
            end
        end
`ifdef PLIC_SRC_EVENT_CNT_EN
        m_cnt = (sel < N) ? 16'(m_evt[sel]) : 16'd0;
        for (int k = 0; k < N; k++) begin
            if (cur_clr && sel == k) m_evt[k] = 0;
            else if (m_rise[k] && m_evt[k] < 65535) m_evt[k]++;
        end
`else
        m_cnt = 16'd0;
`endif
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = cur_irq;
        m_rise = nq & ~m_q;
        m_q    = nq;
        e.irq = m_q; e.rise = m_rise; e.cnt = m_cnt;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_irq",  bus.irq_lvl, '0);
        check("async_rise", bus.rise, '0);
        check("async_cnt",  {{(N-16){1'b0}}, bus.cnt}, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every queued prediction against the DUT at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("irq_o",  bus.irq_lvl, e.irq);
                check("rise_o", bus.rise, e.rise);
                check("cnt_o",  {{(N-16){1'b0}}, bus.cnt}, {{(N-16){1'b0}}, e.cnt});
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0;
        model_reset();
        // reset with all lines asserted, bypass everywhere
        cur_irq = '1; cur_pol = '0; cur_en = '0; cur_len = 4'd0;
        cur_sel = 5'd0; cur_clr = 1'b0;
        bus.irq_raw = cur_irq; bus.pol = cur_pol; bus.filt_en = cur_en;
        bus.filt_len = cur_len; bus.cnt_sel = cur_sel; bus.cnt_clr = cur_clr;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_irq",  bus.irq_lvl, '0);
        check("reset_rise", bus.rise, '0);
        rst_n = 1'b1;
        tick(6);
        // polarity on source 2 with line low, then line high
        cur_irq = '0; tick(5);
        cur_pol[2] = 1'b1; tick(5);
        cur_irq[2] = 1'b1; tick(5);
        cur_pol = '0; cur_irq = '0; tick(4);
        // glitch reject on source 5, length 4: 3-cycle then 4-cycle pulse
        cur_en[5] = 1'b1; cur_len = 4'd4;
        cur_irq[5] = 1'b1; tick(3);
        cur_irq[5] = 1'b0; tick(10);
        cur_irq[5] = 1'b1; tick(4);
        cur_irq[5] = 1'b0; tick(12);
        // length change mid-count: 8 -> 2 after 5 differing cycles
        cur_len = 4'd8; cur_en[9] = 1'b1;
        cur_irq[9] = 1'b1; tick(SYNC + 5);
        cur_len = 4'd2; tick(4);
        cur_irq[9] = 1'b0; tick(12);
        // event counter on source 7: three filtered pulses
        cur_en[7] = 1'b1; cur_len = 4'd3; cur_sel = 5'd7;
        for (int p = 0; p < 3; p++) begin
            cur_irq[7] = 1'b1; tick(6);
            cur_irq[7] = 1'b0; tick(6);
        end
        tick(2);
        // fourth pulse with clear coincident with the rise pulse
        cur_irq[7] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cur_clr = m_rise[7];
            step();
        end
        cur_clr = 1'b0; tick(3);
        cur_sel = 5'd31; cur_clr = 1'b1; tick(3);
        cur_clr = 1'b0; cur_sel = 5'd7; tick(3);
        // source 3 mid-count when reset hits, other lines asserted
        cur_en[3] = 1'b1; cur_len = 4'd8; cur_irq[12] = 1'b1; tick(5);
        cur_irq[3] = 1'b1; tick(SYNC + 2);
        async_reset();
        tick(8);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                cur_len = FW'($urandom_range(0, 6));
                cur_en  = N'($urandom);
            end
            if ($urandom_range(0, 40) == 0) cur_pol[$urandom_range(0, N-1)] ^= 1'b1;
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 5) == 0) cur_irq[k] = ~cur_irq[k];
            cur_sel = SW'($urandom_range(0, 31));
            cur_clr = ($urandom_range(0, 19) == 0);
            step();
            if (i == 1500) async_reset();
        end
        cur_clr = 1'b0;
        tick(2);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
